// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - APU frame sequencer: 4/5-step quarter/half-frame pulses and frame IRQ
//
// Optional feature macro: FRAME_IRQ_EN (defined = frame IRQ flag and inhibit
// register built; undefined = irq tied to 0, irq_ack and wr_data[0] ignored).
//
// Parameters:
//   MODE_RESET    - sequence mode after reset (0 = 4-step, 1 = 5-step)
//   INHIBIT_RESET - IRQ inhibit value after reset
// Ports:
//   clk           - system clock
//   rst           - asynchronous active-high reset
//   tick          - 240 Hz single-cycle enable strobe
//   wr_en         - mode register write strobe
//   wr_data[1:0]  - bit 1 = mode, bit 0 = IRQ inhibit
//   irq_ack       - clears a pending frame IRQ
//   quarter_frame - one-cycle pulse for envelopes / linear counter
//   half_frame    - one-cycle pulse for length counters / sweeps
//   irq           - frame interrupt level
//   step          - index of the next step to execute (0-4)

module frame_sequencer #(
    parameter bit MODE_RESET    = 1'b0,
    parameter bit INHIBIT_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       wr_en,
    input  logic [1:0] wr_data,
    input  logic       irq_ack,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       irq,
    output logic [2:0] step
);

    logic       mode;
    logic       last_step;
    logic       quarter_next;
    logic       half_next;
    logic [2:0] step_next;

    // Decode of the step about to execute. Any out-of-range value (5-7, or 4
    // while in 4-step mode) is treated as the final step so the sequence
    // always recovers to 0 on the next tick.
    always_comb begin
        last_step    = 1'b0;
        quarter_next = 1'b1;
        if (mode) begin
            last_step    = (step >= 3'd4);
            quarter_next = (step != 3'd3);
        end else begin
            last_step    = (step >= 3'd3);
            quarter_next = 1'b1;
        end
        half_next = (step == 3'd1) || last_step;
        step_next = last_step ? 3'd0 : step + 3'd1;
    end

    // A write takes priority over a coincident tick; the tick is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode          <= MODE_RESET;
            step          <= 3'd0;
            quarter_frame <= 1'b0;
            half_frame    <= 1'b0;
        end else begin
            quarter_frame <= 1'b0;
            half_frame    <= 1'b0;
            if (wr_en) begin
                mode <= wr_data[1];
                step <= 3'd0;
                // Entering 5-step mode clocks the channel units immediately.
                if (wr_data[1]) begin
                    quarter_frame <= 1'b1;
                    half_frame    <= 1'b1;
                end
            end else if (tick) begin
                quarter_frame <= quarter_next;
                half_frame    <= half_next;
                step          <= step_next;
            end
        end
    end

`ifdef FRAME_IRQ_EN
    logic inhibit;
    logic irq_set;

    assign irq_set = tick && !wr_en && !mode && last_step && !inhibit;

    // Set has priority over a same-cycle acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inhibit <= INHIBIT_RESET;
            irq     <= 1'b0;
        end else begin
            if (wr_en) begin
                inhibit <= wr_data[0];
            end
            if (irq_set) begin
                irq <= 1'b1;
            end else if (irq_ack || (wr_en && wr_data[0])) begin
                irq <= 1'b0;
            end
        end
    end
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{irq_ack, wr_data[0], INHIBIT_RESET};
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - directed table-driven bench for frame_sequencer

module tb_frame_sequencer;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       wr_en;
    logic [1:0] wr_data;
    logic       irq_ack;
    logic       quarter_frame;
    logic       half_frame;
    logic       irq;
    logic [2:0] step;

    int n_vec;
    int n_err;

    frame_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .irq_ack       (irq_ack),
        .quarter_frame (quarter_frame),
        .half_frame    (half_frame),
        .irq           (irq),
        .step          (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic       wr_en;
        logic [1:0] wr_data;
        logic       irq_ack;
        logic       q;
        logic       h;
        logic       irq;
        logic [2:0] step;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic t, input logic w, input logic [1:0] d,
                                input logic a, input logic q, input logic h,
                                input logic i, input logic [2:0] s);
        vec_t v;
        v.tick = t; v.wr_en = w; v.wr_data = d; v.irq_ack = a;
        v.q = q; v.h = h; v.irq = i; v.step = s;
        vecs.push_back(v);
    endfunction

    // Without the IRQ feature the flag must read 0 whatever the table says.
    function automatic logic irq_exp(input logic i);
`ifdef FRAME_IRQ_EN
        return i;
`else
        return 1'b0 & i;
`endif
    endfunction

    task automatic check(input string name, input int idx, input logic [2:0] act,
                         input logic [2:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic q,
                             input logic h, input logic i, input logic [2:0] s);
        check({tag, ".quarter"}, idx, {2'b0, quarter_frame}, {2'b0, q});
        check({tag, ".half"},    idx, {2'b0, half_frame},    {2'b0, h});
        check({tag, ".irq"},     idx, {2'b0, irq},           {2'b0, irq_exp(i)});
        check({tag, ".step"},    idx, step,                  s);
    endtask

    task automatic idle_inputs();
        tick = 1'b0; wr_en = 1'b0; wr_data = 2'b00; irq_ack = 1'b0;
    endtask

    // One active cycle then one idle cycle; the idle check proves the pulse
    // is exactly one cycle wide and step/irq hold.
    task automatic apply(input int idx);
        vec_t v;
        v = vecs[idx];
        @(negedge clk);
        tick = v.tick; wr_en = v.wr_en; wr_data = v.wr_data; irq_ack = v.irq_ack;
        @(posedge clk);
        #1;
        check_all("vec", idx, v.q, v.h, v.irq, v.step);
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        check_all("hold", idx, 1'b0, 1'b0, v.irq, v.step);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle_inputs();
        rst = 1'b1;

        // Columns: tick, wr_en, wr_data, irq_ack | quarter, half, irq, step
        // 4-step from reset, 8 ticks
        add(1, 0, 2'b00, 0, 1, 0, 0, 3'd1);
        add(1, 0, 2'b00, 0, 1, 1, 0, 3'd2);
        add(1, 0, 2'b00, 0, 1, 0, 0, 3'd3);
        add(1, 0, 2'b00, 0, 1, 1, 1, 3'd0);
        add(1, 0, 2'b00, 0, 1, 0, 1, 3'd1);
        add(1, 0, 2'b00, 0, 1, 1, 1, 3'd2);
        add(1, 0, 2'b00, 0, 1, 0, 1, 3'd3);
        add(1, 0, 2'b00, 0, 1, 1, 1, 3'd0);
        // acknowledge, then switch to 5-step and run 5 ticks
        add(0, 0, 2'b00, 1, 0, 0, 0, 3'd0);
        add(0, 1, 2'b10, 0, 1, 1, 0, 3'd0);
        add(1, 0, 2'b00, 0, 1, 0, 0, 3'd1);
        add(1, 0, 2'b00, 0, 1, 1, 0, 3'd2);
        add(1, 0, 2'b00, 0, 1, 0, 0, 3'd3);
        add(1, 0, 2'b00, 0, 0, 0, 0, 3'd4);
        add(1, 0, 2'b00, 0, 1, 1, 0, 3'd0);
        // back to 4-step, raise irq, ack collides with next step-3 tick
        add(0, 1, 2'b00, 0, 0, 0, 0, 3'd0);
        add(1, 0, 2'b00, 0, 1, 0, 0, 3'd1);
        add(1, 0, 2'b00, 0, 1, 1, 0, 3'd2);
        add(1, 0, 2'b00, 0, 1, 0, 0, 3'd3);
        add(1, 0, 2'b00, 0, 1, 1, 1, 3'd0);
        add(1, 0, 2'b00, 0, 1, 0, 1, 3'd1);
        add(1, 0, 2'b00, 0, 1, 1, 1, 3'd2);
        add(1, 0, 2'b00, 0, 1, 0, 1, 3'd3);
        add(1, 0, 2'b00, 1, 1, 1, 1, 3'd0);
        add(0, 0, 2'b00, 1, 0, 0, 0, 3'd0);
        // raise irq, then inhibit write clears it and 4 ticks keep it low
        add(1, 0, 2'b00, 0, 1, 0, 0, 3'd1);
        add(1, 0, 2'b00, 0, 1, 1, 0, 3'd2);
        add(1, 0, 2'b00, 0, 1, 0, 0, 3'd3);
        add(1, 0, 2'b00, 0, 1, 1, 1, 3'd0);
        add(0, 1, 2'b01, 0, 0, 0, 0, 3'd0);
        add(1, 0, 2'b00, 0, 1, 0, 0, 3'd1);
        add(1, 0, 2'b00, 0, 1, 1, 0, 3'd2);
        add(1, 0, 2'b00, 0, 1, 0, 0, 3'd3);
        add(1, 0, 2'b00, 0, 1, 1, 0, 3'd0);
        // write and tick together at step 2: write wins
        add(1, 0, 2'b00, 0, 1, 0, 0, 3'd1);
        add(1, 0, 2'b00, 0, 1, 1, 0, 3'd2);
        add(1, 1, 2'b00, 0, 0, 0, 0, 3'd0);
        add(1, 0, 2'b00, 0, 1, 0, 0, 3'd1);
        add(1, 0, 2'b00, 0, 1, 1, 0, 3'd2);
        add(1, 1, 2'b10, 0, 1, 1, 0, 3'd0);
        // 4-step, inhibit off: irq set, then advance to step 3 for reset test
        add(0, 1, 2'b00, 0, 0, 0, 0, 3'd0);
        add(1, 0, 2'b00, 0, 1, 0, 0, 3'd1);
        add(1, 0, 2'b00, 0, 1, 1, 0, 3'd2);
        add(1, 0, 2'b00, 0, 1, 0, 0, 3'd3);
        add(1, 0, 2'b00, 0, 1, 1, 1, 3'd0);
        add(1, 0, 2'b00, 0, 1, 0, 1, 3'd1);
        add(1, 0, 2'b00, 0, 1, 1, 1, 3'd2);

        // Reset values, including a tick held during reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        check_all("reset", 0, 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        tick = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("reset_rel", 0, 1'b0, 1'b0, 1'b0, 3'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i);
        end

        // Tick from step 2 to 3 with irq set, then reset asynchronously while
        // the quarter pulse is high, between clock edges.
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        check_all("pre_rst", 0, 1'b1, 1'b0, 1'b1, 3'd3);
        tick = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 0, 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst", 0, 1'b1, 1'b0, 1'b0, 3'd1);
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        check_all("post_rst_hold", 0, 1'b0, 1'b0, 1'b0, 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
